booth_mac_acc: RTL and testbench
================================

# booth_mac_acc

Streaming signed accumulator directly downstream of the 8x8 approximate radix-4 Booth multiplier. It consumes the multiplier's 16-bit two's-complement product `p` one term per accepted beat and sums a frame of terms into a wide saturating accumulator. At the end of each frame it presents the dot-product result, term count and saturation flag on a valid/ready output port. It turns the combinational multiplier into a MAC/dot-product engine for the filter datapath.

## Interface
- `ACC_W`, 24: accumulator and result width in bits, signed, >= 17.
- `CNT_W`, 9: term-counter width in bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a product term is presented on `in_p`.
- `in_ready`  out  1  block can accept a term this cycle.
- `in_p`  in  16  signed product from the multiplier output `p`.
- `in_last`  in  1  the presented term is the final term of the frame.
- `out_valid`  out  1  frame result is held on the output.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  signed frame sum, saturated.
- `out_count`  out  CNT_W  number of terms in the frame, saturating.
- `out_sat`  out  1  sticky flag: saturation occurred anywhere in the frame.

## Operation
- A term is accepted when `in_valid && in_ready`. The result is accepted when `out_valid && out_ready`.
- States:
  - IDLE: accumulator cleared, no frame open.
  - ACCUM: frame open.
  - HOLD: result presented.
- Transitions:
  - IDLE to ACCUM on an accepted term without `in_last`.
  - IDLE to HOLD on an accepted term with `in_last` (single-term frame).
  - ACCUM to HOLD on an accepted term with `in_last`.
  - HOLD to IDLE on result acceptance.
- `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD.
- Arithmetic:
  - `in_p` is sign-extended to ACC_W+1 bits and added to the accumulator.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value; if it is below -2^(ACC_W-1), clamp to that value.
  - Either clamp sets the sticky `sat` flag.
  - Accepting the first term of a frame loads the accumulator as 0 + `in_p`, so no dead cycle is needed after HOLD.
- Counter increments per accepted term and saturates at 2^CNT_W-1. Reaching that cap also sets `sat`.
- `out_acc`, `out_count` and `out_sat` are registered. They are stable for the whole of HOLD and reflect the frame including the `in_last` term.
- On leaving HOLD, the accumulator, counter and `sat` clear to 0.
- `in_p` is ignored unless a term is accepted. `in_last` without `in_valid` has no effect.
- Reset mid-frame or mid-HOLD: the frame is discarded with no partial output, and the block returns to IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` = 1 from the first cycle after reset is released, 0 while `rst` is high.
  - `out_valid` = 0, `out_acc` = 0, `out_count` = 0, `out_sat` = 0.
- Throughput: one term per cycle in IDLE/ACCUM.
- Latency: `out_valid` rises on the edge that accepts the `in_last` term, i.e. the result is visible the following cycle.
- Minimum gap between frames:
  - one cycle if `out_ready` is already high when `out_valid` rises, because HOLD lasts exactly one cycle and the next term is accepted the cycle after.
  - otherwise HOLD persists until `out_ready`.
- `out_valid` must not drop without acceptance. Outputs must not change while `out_valid && !out_ready`.
- `in_ready` is a function of registered state only, with no combinational path from `out_ready`.

## Structure
- Shared package `booth_pkg`:
  - `PROD_W` = 16.
  - state enum `mac_state_t` {IDLE, ACCUM, HOLD}.
  - default `ACC_W`/`CNT_W` constants.
- Sub-module `sat_add`: parameterized signed saturating adder (ACC_W accumulator + PROD_W term → ACC_W result, overflow flag). Reused by later accumulator stages.
- Top-level wiring: multiplier output `p` connects directly to `in_p`. Upstream operand staging owns `in_valid`/`in_last`.

## Test plan
- Frame of products 100, -50, 7 with `out_ready` = 1 → one `out_valid` pulse with `out_acc` = 57, `out_count` = 3, `out_sat` = 0; `in_ready` low for exactly one cycle.
- Single-term frame −16384 (`in_last` on first beat) → `out_acc` = −16384, `out_count` = 1, result visible one cycle after acceptance.
- With ACC_W = 17, feed 0x7FFF four times → `out_acc` = 65535, `out_sat` = 1; the next frame (1, last) gives `out_acc` = 1, `out_sat` = 0.
- Hold `out_ready` = 0 for 5 cycles after `out_valid`, while driving `in_valid` = 1 → `in_ready` = 0, outputs stable, no term accepted; release → IDLE, the next term is accepted the following cycle.
- Assert `rst` after 2 of 4 terms → no `out_valid`; the next frame 3, 4 (last) gives `out_acc` = 7, `out_count` = 2.
- Random x,y through the multiplier into the block, 511+ terms with CNT_W = 9 → `out_count` = 511, `out_sat` = 1; scoreboard compares the sum of the multiplier's own outputs.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier / accumulator datapath.
package booth_pkg;

    localparam int PROD_W    = 16;  // multiplier product width
    localparam int ACC_W_DEF = 24;  // default accumulator width
    localparam int CNT_W_DEF = 9;   // default term-counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/booth_mac_acc_sat_add.sv
// Signed saturating adder: ACC_W accumulator plus sign-extended TERM_W term.
// One guard bit is enough because the term is narrower than the accumulator.
module sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int TERM_W = PROD_W
) (
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [TERM_W-1:0] b,
    output logic signed [ACC_W-1:0]  y,
    output logic                     ovf
);

    logic [ACC_W:0] sum;

    // Add at ACC_W+1 bits, then clamp when the guard and sign bits disagree.
    always_comb begin
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-TERM_W){b[TERM_W-1]}}, b};
        ovf = sum[ACC_W] ^ sum[ACC_W-1];
        if (!ovf)
            y = sum[ACC_W-1:0];
        else if (sum[ACC_W])
            y = {1'b1, {(ACC_W-1){1'b0}}};
        else
            y = {1'b0, {(ACC_W-1){1'b1}}};
    end

endmodule

// File: rtl/booth_mac_acc.sv
// Streaming frame accumulator behind the Booth multiplier: sums one signed
// product per accepted beat, presents sum/count/saturation at end of frame.
module booth_mac_acc
    import booth_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_p,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_sat
);

    mac_state_t              state;
    logic signed [ACC_W-1:0] acc, base, sum;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    sat, ovf, rdy_q, vld_q, take;

    // Ready comes from a register; reset forces it low while asserted.
    assign in_ready = rdy_q & ~rst;
    assign take     = in_valid & in_ready;

    // First term of a frame loads 0 + in_p regardless of accumulator contents.
    assign base    = (state == IDLE) ? '0 : acc;
    assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);

    sat_add #(.ACC_W(ACC_W), .TERM_W(PROD_W)) u_add (
        .a   (base),
        .b   (in_p),
        .y   (sum),
        .ovf (ovf)
    );

    // Frame FSM with accumulator, counter, sticky flag and registered handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        sat <= sat | ovf | (&cnt_nxt);
                        if (in_last) begin
                            state <= HOLD;
                            rdy_q <= 1'b0;
                            vld_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        rdy_q <= 1'b1;
                        vld_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = vld_q;
    assign out_acc   = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: two instances (ACC_W=24 and ACC_W=17) share one
// stimulus stream; a frame-level model checks both every cycle.
module tb_booth_mac_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_last, out_ready;
    logic signed [15:0] in_p;

    logic               rdy0, vld0, sat0;
    logic signed [23:0] acc0;
    logic [8:0]         cnt0;
    logic               rdy1, vld1, sat1;
    logic signed [16:0] acc1;
    logic [8:0]         cnt1;

    booth_mac_acc u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_p(in_p),
        .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
        .out_acc(acc0), .out_count(cnt0), .out_sat(sat0)
    );

    booth_mac_acc #(.ACC_W(17), .CNT_W(9)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_p(in_p),
        .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
        .out_acc(acc1), .out_count(cnt1), .out_sat(sat1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: per instance, a "result pending" bit and the running frame sum,
    // clamped to the instance's signed range after every added term.
    int     accw [2] = '{24, 17};
    bit     m_hold [2];
    longint m_acc [2];
    int     m_cnt [2];
    bit     m_sat [2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint hi, lo, s;
            hi = (longint'(1) <<< (accw[k] - 1)) - 1;
            lo = -hi - 1;
            if (rst) begin
                m_hold[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
            end else if (m_hold[k]) begin
                if (out_ready) begin
                    m_hold[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
                end
            end else if (in_valid) begin
                s = m_acc[k] + longint'(in_p);
                if (s > hi) begin s = hi; m_sat[k] = 1; end
                if (s < lo) begin s = lo; m_sat[k] = 1; end
                m_acc[k] = s;
                if (m_cnt[k] < 511) m_cnt[k]++;
                if (m_cnt[k] == 511) m_sat[k] = 1;
                if (in_last) m_hold[k] = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("rdy0", longint'(rdy0), longint'(!m_hold[0] && !rst));
        chk("vld0", longint'(vld0), longint'(m_hold[0]));
        chk("acc0", longint'(acc0), m_acc[0]);
        chk("cnt0", longint'(cnt0), longint'(m_cnt[0]));
        chk("sat0", longint'(sat0), longint'(m_sat[0]));
        chk("rdy1", longint'(rdy1), longint'(!m_hold[1] && !rst));
        chk("vld1", longint'(vld1), longint'(m_hold[1]));
        chk("acc1", longint'(acc1), m_acc[1]);
        chk("cnt1", longint'(cnt1), longint'(m_cnt[1]));
        chk("sat1", longint'(sat1), longint'(m_sat[1]));
    endtask

    // One clock: inputs were set at the previous falling edge; outputs are
    // compared on the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit v, input int p, input bit last, input bit ordy);
        in_valid  = v;
        in_p      = 16'(p);
        in_last   = last;
        out_ready = ordy;
    endtask

    typedef struct {
        bit v; int p; bit last; bit ordy;
        bit rdy; bit vld; int acc; int cnt; bit sat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // frame 100, -50, 7 then single-term frame -16384, out_ready held high
        tbl[0] = '{1, 100,    0, 1,  1, 0, 100,    1, 0};
        tbl[1] = '{1, -50,    0, 1,  1, 0, 50,     2, 0};
        tbl[2] = '{1, 7,      1, 1,  0, 1, 57,     3, 0};
        tbl[3] = '{0, 0,      0, 1,  1, 0, 0,      0, 0};
        tbl[4] = '{1, -16384, 1, 1,  0, 1, -16384, 1, 0};
        tbl[5] = '{0, 0,      0, 1,  1, 0, 0,      0, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        chk("rst_rdy_low", longint'(rdy0), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("reset_acc", longint'(acc0), 0);
        chk("reset_vld", longint'(vld0), 0);
        chk("reset_rdy", longint'(rdy0), 1);

        // table-driven vectors against the 24-bit instance
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].last, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d_rdy", i), longint'(rdy0), longint'(tbl[i].rdy));
            chk($sformatf("tbl%0d_vld", i), longint'(vld0), longint'(tbl[i].vld));
            chk($sformatf("tbl%0d_acc", i), longint'(acc0), longint'(tbl[i].acc));
            chk($sformatf("tbl%0d_cnt", i), longint'(cnt0), longint'(tbl[i].cnt));
            chk($sformatf("tbl%0d_sat", i), longint'(sat0), longint'(tbl[i].sat));
        end

        // 0x7FFF x4: clamps at 17 bits, fits in 24 bits
        for (int i = 0; i < 4; i++) begin
            drive(1, 32767, i == 3, 1);
            tick();
        end
        chk("sat17_acc", longint'(acc1), 65535);
        chk("sat17_flag", longint'(sat1), 1);
        chk("sat24_acc", longint'(acc0), 131068);
        chk("sat24_flag", longint'(sat0), 0);
        drive(0, 0, 0, 1);
        tick();
        drive(1, 1, 1, 1);
        tick();
        chk("after_sat_acc", longint'(acc1), 1);
        chk("after_sat_flag", longint'(sat1), 0);
        drive(0, 0, 0, 1);
        tick();

        // backpressure: result held 5 cycles while in_valid stays high
        drive(1, 5, 0, 0);
        tick();
        drive(1, 6, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 999, 0, 0);
            tick();
            chk("bp_rdy", longint'(rdy0), 0);
            chk("bp_acc", longint'(acc0), 11);
            chk("bp_cnt", longint'(cnt0), 2);
        end
        drive(1, 3, 0, 1);
        tick();
        chk("bp_release_vld", longint'(vld0), 0);
        tick();
        chk("bp_next_acc", longint'(acc0), 3);
        chk("bp_next_cnt", longint'(cnt0), 1);

        // reset after 2 of 4 terms (3 already in, add 9), frame discarded
        drive(1, 9, 0, 1);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_vld", longint'(vld0), 0);
        chk("rst_mid_acc", longint'(acc0), 0);
        drive(1, 3, 0, 1);
        tick();
        drive(1, 4, 1, 1);
        tick();
        chk("post_rst_acc", longint'(acc0), 7);
        chk("post_rst_cnt", longint'(cnt0), 2);
        drive(0, 0, 0, 1);
        tick();

        // long random frame of 8x8 signed products: count caps at 511
        begin
            int     sent = 0;
            longint total = 0, maxabs = 0;
            for (int c = 0; c < 5000 && sent < 520; c++) begin
                bit v;
                int x, y;
                v = ($urandom_range(3) != 0);
                x = $signed(8'($urandom));
                y = $signed(8'($urandom));
                drive(v, x * y, sent == 519, 1);
                if (v && !m_hold[0]) begin
                    sent++;
                    total += x * y;
                    if (total > maxabs) maxabs = total;
                    if (-total > maxabs) maxabs = -total;
                end
                tick();
            end
            chk("rand_terms", sent, 520);
            chk("rand_cnt", longint'(cnt0), 511);
            chk("rand_sat", longint'(sat0), 1);
            chk("rand_vld", longint'(vld0), 1);
            if (maxabs < (longint'(1) <<< 23))
                chk("rand_sum", longint'(acc0), total);
            drive(0, 0, 0, 1);
            tick();
        end

        // short random frames with random backpressure
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(3) != 0, $signed(16'($urandom)),
                  $urandom_range(5) == 0, $urandom_range(2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
